// File: rtl/day10_one_bit_comparator.sv
// Single-bit magnitude comparator with optionally registered one-hot result
// and per-outcome saturating event counters.
module day10_one_bit_comparator #(
  parameter int unsigned CNT_W   = 8,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic             g,
  output logic             e,
  output logic             s,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic gt_c, eq_c, lt_c;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;

  always_comb begin
    gt_c = a & ~b;
    eq_c = ~(a ^ b);
    lt_c = ~a & b;
  end

  // Only the counter matching this sample's outcome moves; saturated counters hold.
  always_comb begin
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    lt_cnt_d = lt_cnt_q;
    if (in_valid) begin
      if (gt_c && gt_cnt_q != CntMax) gt_cnt_d = gt_cnt_q + 1'b1;
      if (eq_c && eq_cnt_q != CntMax) eq_cnt_d = eq_cnt_q + 1'b1;
      if (lt_c && lt_cnt_q != CntMax) lt_cnt_d = lt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      gt_cnt_q <= gt_cnt_d;
      eq_cnt_q <= eq_cnt_d;
      lt_cnt_q <= lt_cnt_d;
    end
  end

  assign gt_cnt = gt_cnt_q;
  assign eq_cnt = eq_cnt_q;
  assign lt_cnt = lt_cnt_q;

  if (REG_OUT) begin : g_reg_out
    logic g_q, e_q, s_q, valid_q;

    // Result tracks a/b every cycle; in_valid only qualifies it.
    always_ff @(posedge clk) begin
      if (rst) begin
        g_q     <= 1'b0;
        e_q     <= 1'b0;
        s_q     <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        g_q     <= gt_c;
        e_q     <= eq_c;
        s_q     <= lt_c;
        valid_q <= in_valid;
      end
    end

    assign g         = g_q;
    assign e         = e_q;
    assign s         = s_q;
    assign out_valid = valid_q;
  end else begin : g_comb_out
    assign g         = gt_c;
    assign e         = eq_c;
    assign s         = lt_c;
    assign out_valid = in_valid & ~rst;
  end

endmodule

// File: tb/tb_day10_one_bit_comparator.sv
// Drives one registered (8-bit counters) and one combinational (2-bit counters)
// comparator from shared stimulus and checks both against a tally model.
module tb_day10_one_bit_comparator;

  logic clk = 1'b0;
  logic rst, a, b, in_valid;

  logic       g_r, e_r, s_r, ov_r;
  logic [7:0] gt_r, eq_r, lt_r;
  logic       g_c, e_c, s_c, ov_c;
  logic [1:0] gt_c, eq_c, lt_c;

  int checks = 0;
  int errors = 0;

  // Reference state: raw outcome tallies and expected registered result.
  int n_gt, n_eq, n_lt;
  int exp_g, exp_e, exp_s, exp_ov;

  always #5 clk = ~clk;

  day10_one_bit_comparator #(.CNT_W(8), .REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .g(g_r), .e(e_r), .s(s_r), .out_valid(ov_r),
    .gt_cnt(gt_r), .eq_cnt(eq_r), .lt_cnt(lt_r)
  );

  day10_one_bit_comparator #(.CNT_W(2), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .g(g_c), .e(e_c), .s(s_c), .out_valid(ov_c),
    .gt_cnt(gt_c), .eq_cnt(eq_c), .lt_cnt(lt_c)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // One clock: drive at negedge, check combinational outputs, update model at
  // posedge, then check registered outputs and counters.
  task automatic step(input bit ai, input bit bi, input bit vi, input bit ri);
    @(negedge clk);
    a = ai; b = bi; in_valid = vi; rst = ri;
    #1;
    check("comb_g", g_c, int'(ai) > int'(bi));
    check("comb_e", e_c, int'(ai) == int'(bi));
    check("comb_s", s_c, int'(ai) < int'(bi));
    check("comb_ov", ov_c, (vi && !ri) ? 1 : 0);
    check("comb_onehot", $countones({g_c, e_c, s_c}), 1);
    @(posedge clk);
    if (ri) begin
      n_gt = 0; n_eq = 0; n_lt = 0;
      exp_g = 0; exp_e = 0; exp_s = 0; exp_ov = 0;
    end else begin
      exp_g  = int'(ai) > int'(bi);
      exp_e  = int'(ai) == int'(bi);
      exp_s  = int'(ai) < int'(bi);
      exp_ov = vi;
      if (vi) begin
        if (int'(ai) > int'(bi)) n_gt++;
        else if (ai == bi) n_eq++;
        else n_lt++;
      end
    end
    #1;
    check("reg_g", g_r, exp_g);
    check("reg_e", e_r, exp_e);
    check("reg_s", s_r, exp_s);
    check("reg_ov", ov_r, exp_ov);
    if (!ri) check("reg_onehot", $countones({g_r, e_r, s_r}), 1);
    check("gt_cnt8", gt_r, sat(n_gt, 8));
    check("eq_cnt8", eq_r, sat(n_eq, 8));
    check("lt_cnt8", lt_r, sat(n_lt, 8));
    check("gt_cnt2", gt_c, sat(n_gt, 2));
    check("eq_cnt2", eq_c, sat(n_eq, 2));
    check("lt_cnt2", lt_c, sat(n_lt, 2));
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; b = 1'b0; in_valid = 1'b0;
    n_gt = 0; n_eq = 0; n_lt = 0;
    exp_g = 0; exp_e = 0; exp_s = 0; exp_ov = 0;

    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);

    // Truth table with every sample qualified.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("tt_gt_cnt", gt_r, 1);
    check("tt_eq_cnt", eq_r, 2);
    check("tt_lt_cnt", lt_r, 1);

    // Unqualified samples still drive the result but leave counters alone.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_g", g_r, 1);
    check("hold_ov", ov_r, 0);

    // Saturation of the 2-bit counters while the others keep counting.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("sat_eq2", eq_c, 3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("sat_gt2", gt_c, 2);
    check("sat_eq2_hold", eq_c, 3);

    // Reset mid-operation drops the presented sample.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("rst_lt8", lt_r, 0);
    check("rst_ov", ov_r, 0);

    // Restart saturation check from a clean state to match the directed case.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("sat2_gt", gt_c, 1);
    check("sat2_eq", eq_c, 3);

    // Zero-latency response of the combinational variant between edges.
    a = 1'b0; b = 1'b0; in_valid = 1'b0; rst = 1'b0;
    #1;
    check("zl_e_before", e_c, 1);
    check("zl_s_before", s_c, 0);
    b = 1'b1;
    #1;
    check("zl_e_after", e_c, 0);
    check("zl_s_after", s_c, 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 59) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
